// File: rtl/glip_bb_host_bridge_if.sv
// GLIP host word channel between the debug host and the blackbone host bridge.
// The master modport is the host side, the slave modport is the bridge side.
interface glip_bb_host_bridge_if #(
  parameter int GLIP_WIDTH = 16
);
  logic [GLIP_WIDTH-1:0] glip_in_data;
  logic                  glip_in_valid;
  logic                  glip_in_ready;
  logic [GLIP_WIDTH-1:0] glip_out_data;
  logic                  glip_out_valid;
  logic                  glip_out_ready;

  modport master (
    output glip_in_data,
    output glip_in_valid,
    input  glip_in_ready,
    input  glip_out_data,
    input  glip_out_valid,
    output glip_out_ready
  );

  modport slave (
    input  glip_in_data,
    input  glip_in_valid,
    output glip_in_ready,
    output glip_out_data,
    output glip_out_valid,
    input  glip_out_ready
  );
endinterface

// File: rtl/glip_bb_host_bridge.sv
// Decodes GLIP read/write burst commands and masters the blackbone external bus,
// returning the echoed header and read data on the GLIP output channel.
module glip_bb_host_bridge #(
  parameter int GLIP_WIDTH = 16,
  parameter int BB_AW      = 16,
  parameter int BB_DW      = 16,
  parameter int LEN_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  glip_bb_host_bridge_if.slave glip,
  output logic [BB_AW-1:0]     bb_addr_o,
  output logic [BB_DW-1:0]     bb_din_o,
  output logic                 bb_en_o,
  output logic [1:0]           bb_we_o,
  input  logic [BB_DW-1:0]     bb_dout_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WBUS  = 3'd3;
  localparam logic [2:0] S_RHDR  = 3'd4;
  localparam logic [2:0] S_RBUS  = 3'd5;
  localparam logic [2:0] S_RCAP  = 3'd6;
  localparam logic [2:0] S_RPUSH = 3'd7;

  localparam logic [BB_AW-1:0]    ADDR_ONE = {{(BB_AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0] CNT_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0] CNT_ZERO = {LEN_BITS{1'b0}};

  // Header bits between the W flag and the length field are reserved and must be zero.
  function automatic logic hdr_reserved_bad(input logic [GLIP_WIDTH-1:0] hdr);
    return (hdr[GLIP_WIDTH-2:LEN_BITS] != {(GLIP_WIDTH-1-LEN_BITS){1'b0}});
  endfunction

  logic [2:0]            state_r;
  logic [2:0]            state_nx_s;
  logic                  wr_r;
  logic [LEN_BITS-1:0]   cnt_r;
  logic [GLIP_WIDTH-1:0] hdr_r;
  logic                  in_ready_r;
  logic [GLIP_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic [BB_AW-1:0]      addr_r;
  logic [BB_DW-1:0]      din_r;
  logic                  en_r;
  logic [1:0]            we_r;
  logic                  busy_r;
  logic                  err_r;
  logic                  in_fire_s;
  logic                  out_fire_s;
  logic                  hdr_bad_s;

  assign in_fire_s  = glip.glip_in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & glip.glip_out_ready;
  assign hdr_bad_s  = hdr_reserved_bad(glip.glip_in_data);

  assign glip.glip_in_ready  = in_ready_r;
  assign glip.glip_out_data  = out_data_r;
  assign glip.glip_out_valid = out_valid_r;
  assign bb_addr_o = addr_r;
  assign bb_din_o  = din_r;
  assign bb_en_o   = en_r;
  assign bb_we_o   = we_r;
  assign busy_o    = busy_r;
  assign err_o     = err_r;

  // Next-state decode of the burst sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_fire_s && !hdr_bad_s) state_nx_s = S_ADDR;
        else                         state_nx_s = S_IDLE;
      end
      S_ADDR: begin
        if (in_fire_s) state_nx_s = wr_r ? S_WDATA : S_RHDR;
        else           state_nx_s = S_ADDR;
      end
      S_WDATA: begin
        if (in_fire_s) state_nx_s = S_WBUS;
        else           state_nx_s = S_WDATA;
      end
      S_WBUS: begin
        if (cnt_r == CNT_ZERO) state_nx_s = S_IDLE;
        else                   state_nx_s = S_WDATA;
      end
      S_RHDR: begin
        if (out_fire_s) state_nx_s = S_RBUS;
        else            state_nx_s = S_RHDR;
      end
      S_RBUS:  state_nx_s = S_RCAP;
      S_RCAP:  state_nx_s = S_RPUSH;
      S_RPUSH: begin
        if (out_fire_s) state_nx_s = (cnt_r == CNT_ZERO) ? S_IDLE : S_RBUS;
        else            state_nx_s = S_RPUSH;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; strobes/ready are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      wr_r        <= 1'b0;
      cnt_r       <= CNT_ZERO;
      hdr_r       <= {GLIP_WIDTH{1'b0}};
      in_ready_r  <= 1'b0;
      out_data_r  <= {GLIP_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      addr_r      <= {BB_AW{1'b0}};
      din_r       <= {BB_DW{1'b0}};
      en_r        <= 1'b0;
      we_r        <= 2'b00;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == S_IDLE) || (state_nx_s == S_ADDR) || (state_nx_s == S_WDATA);
      busy_r     <= (state_nx_s != S_IDLE);
      en_r       <= (state_nx_s == S_WBUS) || (state_nx_s == S_RBUS);
      we_r       <= (state_nx_s == S_WBUS) ? 2'b11 : 2'b00;
      err_r      <= (state_r == S_IDLE) && in_fire_s && hdr_bad_s;
      case (state_r)
        S_IDLE: begin
          if (in_fire_s && !hdr_bad_s) begin
            wr_r  <= glip.glip_in_data[GLIP_WIDTH-1];
            cnt_r <= glip.glip_in_data[LEN_BITS-1:0];
            hdr_r <= glip.glip_in_data;
          end
        end
        S_ADDR: begin
          if (in_fire_s) begin
            addr_r <= glip.glip_in_data;
            if (!wr_r) begin
              out_data_r  <= hdr_r;
              out_valid_r <= 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (in_fire_s) din_r <= glip.glip_in_data;
        end
        S_WBUS: begin
          addr_r <= addr_r + ADDR_ONE;
          if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
        end
        S_RHDR: begin
          if (out_fire_s) out_valid_r <= 1'b0;
        end
        S_RBUS: begin
          out_valid_r <= 1'b0;
        end
        // Read data is valid on the bus the cycle after the strobe.
        S_RCAP: begin
          out_data_r  <= bb_dout_i;
          out_valid_r <= 1'b1;
          addr_r      <= addr_r + ADDR_ONE;
        end
        S_RPUSH: begin
          if (out_fire_s) begin
            out_valid_r <= 1'b0;
            if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/glip_bb_host_bridge.md
Name: glip_bb_host_bridge

Overview:
- Upstream host-access stage for msp430_mpsoc2d.
- Consumes the 16-bit GLIP host word stream, decodes read/write burst commands, and masters the blackbone external bus (bb_ext_*).
- Returns read data to the host on the GLIP output channel.
- Gives the debug host direct word access to the external blackbone address space without a CPU.

Parameters:
- GLIP_WIDTH, 16, GLIP word width; must equal BB_DW.
- BB_AW, 16, blackbone word-address width.
- BB_DW, 16, blackbone data width.
- LEN_BITS, 8, burst length field width; a burst carries LEN+1 words (1..256).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- glip_in_data  in  GLIP_WIDTH  host command/data word
- glip_in_valid  in  1  host word valid
- glip_in_ready  out  1  bridge accepts host word
- glip_out_data  out  GLIP_WIDTH  response word
- glip_out_valid  out  1  response word valid
- glip_out_ready  in  1  host accepts response word
- bb_addr_o  out  BB_AW  blackbone word address
- bb_din_o  out  BB_DW  blackbone write data
- bb_en_o  out  1  blackbone access strobe, one cycle per word
- bb_we_o  out  2  byte write enables; 2'b11 on write, 2'b00 on read
- bb_dout_i  in  BB_DW  blackbone read data, valid the cycle after bb_en_o
- busy_o  out  1  high while state != IDLE
- err_o  out  1  one-cycle pulse on a malformed header

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset all outputs are 0, FSM returns to IDLE, and any in-flight burst is dropped with no bus strobe issued.
- Handshake: a word transfers on a cycle where valid && ready are both high. glip_out_data and glip_out_valid are registered and held stable until glip_out_ready is seen.
- Header word format:
  - bit15 = W (1 write, 0 read)
  - bits[14:LEN_BITS] must be 0
  - bits[LEN_BITS-1:0] = LEN
- FSM states:
  - IDLE: glip_in_ready=1. On header accept:
    - reserved bits nonzero -> pulse err_o, discard the word, stay in IDLE.
    - otherwise latch W and cnt=LEN, go to ADDR.
  - ADDR: glip_in_ready=1. On accept, latch bb_addr_o. Go to WDATA if W=1; go to RHDR if W=0.
  - WDATA: glip_in_ready=1. On accept, latch bb_din_o, go to WBUS.
  - WBUS: glip_in_ready=0, bb_en_o=1, bb_we_o=2'b11 for exactly this cycle.
    - Next cycle: bb_addr_o+1 (wraps modulo 2^BB_AW).
    - If cnt==0 go to IDLE; else cnt-1 and go to WDATA.
  - RHDR: drive glip_out_data = the received header echoed unchanged, glip_out_valid=1. On out handshake go to RBUS.
  - RBUS: bb_en_o=1, bb_we_o=2'b00 for exactly one cycle, go to RCAP.
  - RCAP: capture bb_dout_i into glip_out_data, set glip_out_valid=1, bb_addr_o+1, go to RPUSH.
  - RPUSH: hold the word until glip_out_ready.
    - On handshake: cnt==0 -> IDLE; else cnt-1 and go to RBUS.
- Timing:
  - Write throughput: 2 cycles per word with the host streaming back-to-back.
  - Read throughput: 3 cycles per word with glip_out_ready held high.
  - First read bus strobe occurs the cycle after the header-echo handshake.
- Rules:
  - glip_in_ready=0 in RHDR, RBUS, RCAP, RPUSH and WBUS.
  - No new command is accepted until the current burst completes.
  - bb_en_o is never asserted in IDLE, ADDR or WDATA.
  - glip_out_valid is never dropped without a handshake, except by rst.
  - Address 16'hFFFF followed by one more word wraps to 16'h0000.
  - A host stall inside a write burst (glip_in_valid low in WDATA) leaves the bus idle; bb_addr_o and cnt hold.
  - rst asserted mid-burst: the next cycle after release sits in IDLE and the remaining host words are treated as headers (the host must resynchronise).
- Widths: cnt is LEN_BITS wide. Address increment is an unsigned BB_AW-bit add.

Test Plan:
- Write burst: send 16'h8002, 16'h0100, 16'hAAAA, 16'hBBBB, 16'hCCCC -> three single-cycle bb_en_o strobes with we=2'b11 at addr 0x0100/0x0101/0x0102 carrying AAAA/BBBB/CCCC, then busy_o=0.
- Read burst: model memory 0x0200=1234, 0x0201=5678; send 16'h0001, 16'h0200 -> glip_out emits 0001, 1234, 5678; exactly two read strobes with we=2'b00.
- Backpressure: repeat the read with glip_out_ready low for 5 cycles after each valid -> data held stable and unchanged, no extra bus strobes, same sequence delivered.
- Address wrap: write LEN=1 at address 16'hFFFF -> strobes at FFFF then 0000.
- Malformed header: send 16'h4000 -> err_o pulses exactly one cycle, no bus activity, FSM stays IDLE; a following valid read executes normally.
- Reset mid-operation: assert rst during the second word of a 4-word write -> all outputs 0 immediately, no further strobes; after release, a fresh 1-word write completes correctly.
